// File: rtl/delay_line_ctrl_if.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl_if
//
// Bundle of every non-clock signal between the pulse delay line controller
// and its surroundings: the config handshake, the level enable, the FIFO
// control/flag pins and the status outputs.
//
// Modports:
//   master : the environment (config source, FIFO flags, enable level).
//   slave  : the controller (delay_line_ctrl).
//
// Config handshake (valid/ready): the master presents cfg_delay together with
// cfg_valid and must hold both stable until it sees cfg_ready; a transfer
// happens on every rising clk edge where cfg_valid && cfg_ready are both high.
// cfg_ready never depends on cfg_valid. A transferred value outside the legal
// range is dropped and reported by a one-cycle cfg_err pulse.
//
// Signals:
//   enable      m->s  1        run the delay line while high
//   cfg_delay   m->s  DELAY_W  requested delay in clk cycles
//   cfg_valid   m->s  1        cfg_delay is valid
//   cfg_ready   s->m  1        controller accepts a config this cycle
//   cfg_err     s->m  1        pulse: out-of-range config dropped
//   fifo_full   m->s  1        FIFO full flag
//   fifo_empty  m->s  1        FIFO empty flag
//   fifo_rst    s->m  1        FIFO reset
//   fifo_wr_en  s->m  1        FIFO write enable
//   fifo_rd_en  s->m  1        FIFO read enable
//   delay_cur   s->m  DELAY_W  delay currently applied
//   state_o     s->m  3        controller state (debug)
//   running     s->m  1        high only while streaming
//   ovf_err     s->m  1        sticky overflow flag
//   udf_err     s->m  1        sticky underflow flag
// -----------------------------------------------------------------------------
interface delay_line_ctrl_if #(
    parameter int DELAY_W = 10
);
    logic               enable;
    logic [DELAY_W-1:0] cfg_delay;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_err;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_rst;
    logic               fifo_wr_en;
    logic               fifo_rd_en;
    logic [DELAY_W-1:0] delay_cur;
    logic [2:0]         state_o;
    logic               running;
    logic               ovf_err;
    logic               udf_err;

    modport master (
        output enable,
        output cfg_delay,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err,
        output fifo_full,
        output fifo_empty,
        input  fifo_rst,
        input  fifo_wr_en,
        input  fifo_rd_en,
        input  delay_cur,
        input  state_o,
        input  running,
        input  ovf_err,
        input  udf_err
    );

    modport slave (
        input  enable,
        input  cfg_delay,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err,
        input  fifo_full,
        input  fifo_empty,
        output fifo_rst,
        output fifo_wr_en,
        output fifo_rd_en,
        output delay_cur,
        output state_o,
        output running,
        output ovf_err,
        output udf_err
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
//
// Sequencer for the single-bit FIFO pulse delay line that sits between the
// pulse synchronizer and the TTL output. The delay (FIFO occupancy) is
// programmable at run time over a valid/ready config port. Whenever the delay
// changes or the line is (re-)enabled the FIFO is reset, given time to leave
// its reset-busy window, prefilled with exactly delay_cur entries and then
// streamed with one write and one read every cycle, which keeps the occupancy
// and therefore the delay constant. Any FIFO overflow/underflow stops the
// line and raises a sticky flag.
//
// Ports:
//   clk      in   system clock (100 MHz domain)
//   rst      in   synchronous, active-high reset
//   ctrl_if  slave modport of delay_line_ctrl_if (config, FIFO, status)
//
// State encoding on state_o: IDLE=0, FLUSH=1, FILL=2, RUN=3, ERROR=4.
//
// Every output is either a flop or a decode of flops; no input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module delay_line_ctrl #(
    parameter int DEPTH         = 1024,
    parameter int DELAY_W       = $clog2(DEPTH),
    parameter int DEFAULT_DELAY = 50,
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    delay_line_ctrl_if.slave     ctrl_if
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Largest delay that still leaves headroom in the FIFO for the one extra
    // entry written in the same cycle as a read.
    localparam logic [DELAY_W-1:0] MAX_DELAY  = DELAY_W'(DEPTH - 2);
    localparam logic [DELAY_W-1:0] RST_DELAY  = DELAY_W'(DEFAULT_DELAY);
    // FLUSH counter: 0..RST_CYCLES-1 hold fifo_rst, the rest is settle time.
    localparam logic [DELAY_W-1:0] RST_END    = DELAY_W'(RST_CYCLES);
    localparam logic [DELAY_W-1:0] FLUSH_LAST = DELAY_W'(RST_CYCLES + SETTLE_CYCLES - 1);
    localparam logic [DELAY_W-1:0] CNT_MAX    = {DELAY_W{1'b1}};
    localparam logic [DELAY_W-1:0] CNT_ONE    = DELAY_W'(1);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               cfg_err_q, cfg_err_d;
    // Registered copy of rst so fifo_rst can be high during reset without a
    // combinational path from the rst pin.
    logic               rst_seen_q;

    // -------------------------------------------------------------------------
    // Config handshake decode
    // -------------------------------------------------------------------------
    logic cfg_ready_w;
    logic cfg_fire;
    logic cfg_legal;

    // Configs are refused while a flush/fill is in progress so the fill length
    // cannot change underneath the counter.
    assign cfg_ready_w = (state_q == ST_IDLE) || (state_q == ST_RUN) ||
                         (state_q == ST_ERROR);
    assign cfg_fire    = ctrl_if.cfg_valid && cfg_ready_w;
    assign cfg_legal   = (ctrl_if.cfg_delay != '0) &&
                         (ctrl_if.cfg_delay <= MAX_DELAY);

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        rst_seen_q <= rst;
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            delay_q   <= RST_DELAY;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            delay_q   <= delay_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        cfg_err_d = 1'b0;
        // Saturating increment; each state decides how it uses it.
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        // Config transfer: a legal value always lands in delay_reg, even if
        // the line is being disabled in the same cycle.
        if (cfg_fire) begin
            if (cfg_legal) begin
                delay_d = ctrl_if.cfg_delay;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_if.enable) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // Park the counter on the last settle cycle so a FIFO that is
                // slow to report empty can be waited on indefinitely.
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d = cnt_q;
                    if (ctrl_if.fifo_empty) begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (ctrl_if.fifo_full) begin
                    ovf_d   = 1'b1;
                    state_d = ST_ERROR;
                end else if (cnt_q == delay_q - CNT_ONE) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (ctrl_if.fifo_full || ctrl_if.fifo_empty) begin
                    ovf_d   = ovf_q | ctrl_if.fifo_full;
                    udf_d   = udf_q | ctrl_if.fifo_empty;
                    state_d = ST_ERROR;
                end
            end

            ST_ERROR: begin
                state_d = ST_ERROR;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new legal delay restarts the line; it also overrides a flag event
        // seen in the same RUN cycle because the FIFO is about to be reset.
        if (cfg_fire && cfg_legal && ctrl_if.enable) begin
            state_d = ST_FLUSH;
        end

        // Disable wins over everything except rst.
        if (!ctrl_if.enable) begin
            state_d = ST_IDLE;
        end

        // Flags only get set on the way into ERROR, so clearing them whenever
        // the next state is FLUSH or IDLE is exactly "clear on entry".
        if ((state_d == ST_FLUSH) || (state_d == ST_IDLE)) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        // Every state starts counting from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (flops and decodes of flops only)
    // -------------------------------------------------------------------------
    assign ctrl_if.cfg_ready  = cfg_ready_w;
    assign ctrl_if.cfg_err    = cfg_err_q;
    assign ctrl_if.fifo_rst   = rst_seen_q ||
                                ((state_q == ST_FLUSH) && (cnt_q < RST_END));
    assign ctrl_if.fifo_wr_en = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign ctrl_if.fifo_rd_en = (state_q == ST_RUN);
    assign ctrl_if.delay_cur  = delay_q;
    assign ctrl_if.state_o    = state_q;
    assign ctrl_if.running    = (state_q == ST_RUN);
    assign ctrl_if.ovf_err    = ovf_q;
    assign ctrl_if.udf_err    = udf_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_delay_line_ctrl
//
// Directed bench for delay_line_ctrl with a behavioural single-bit FIFO
// attached. The FIFO model registers dout on the same edge that performs the
// read, so a pulse written in RUN reappears exactly delay_cur cycles later.
// fifo_full / fifo_empty can be forced to exercise the error paths.
// -----------------------------------------------------------------------------
module tb_delay_line_ctrl;

    localparam int DEPTH         = 1024;
    localparam int DELAY_W       = 10;
    localparam int DEFAULT_DELAY = 50;
    localparam int RST_CYCLES    = 8;
    localparam int SETTLE_CYCLES = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_line_ctrl_if #(.DELAY_W(DELAY_W)) bus ();

    delay_line_ctrl #(
        .DEPTH         (DEPTH),
        .DELAY_W       (DELAY_W),
        .DEFAULT_DELAY (DEFAULT_DELAY),
        .RST_CYCLES    (RST_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus.slave)
    );

    // ---------------- FIFO model ----------------
    logic din         = 1'b0;
    logic dout        = 1'b0;
    logic fifo_q[$];
    int   occ         = 0;
    logic force_full  = 1'b0;
    logic force_empty = 1'b0;

    assign bus.fifo_full  = force_full  | (occ >= DEPTH);
    assign bus.fifo_empty = force_empty | (occ == 0);

    always @(posedge clk) begin
        if (bus.fifo_rst) begin
            fifo_q.delete();
            dout <= 1'b0;
        end else begin
            if (bus.fifo_rd_en && fifo_q.size() > 0) dout <= fifo_q.pop_front();
            else                                    dout <= 1'b0;
            if (bus.fifo_wr_en && fifo_q.size() < DEPTH) fifo_q.push_back(din);
        end
        occ <= fifo_q.size();
    end

    // fifo_rst must never stay high longer than the reset window inside FLUSH.
    int rst_run = 0;
    always @(negedge clk) begin
        if (bus.state_o == S_FLUSH && bus.fifo_rst) rst_run = rst_run + 1;
        else                                         rst_run = 0;
        assert (rst_run <= RST_CYCLES)
            else $error("FAIL flush_rst_overrun: fifo_rst high %0d cycles in FLUSH, limit %0d",
                        rst_run, RST_CYCLES);
    end

    // ---------------- scoreboard / helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},     bus.state_o,    S_IDLE);
        check({tag, "_fifo_rst"},  bus.fifo_rst,   1);
        check({tag, "_cfg_ready"}, bus.cfg_ready,  1);
        check({tag, "_delay"},     bus.delay_cur,  DEFAULT_DELAY);
        check({tag, "_wr"},        bus.fifo_wr_en, 0);
        check({tag, "_rd"},        bus.fifo_rd_en, 0);
        check({tag, "_running"},   bus.running,    0);
        check({tag, "_ovf"},       bus.ovf_err,    0);
        check({tag, "_udf"},       bus.udf_err,    0);
        check({tag, "_cfg_err"},   bus.cfg_err,    0);
    endtask

    // Called on the first FLUSH cycle; follows the line into RUN.
    task automatic run_flush_fill(input int exp_delay, input string tag);
        int hi = 0;
        int lo = 0;
        int fill = 0;
        int rdy_bad = 0;
        int n = 0;
        check({tag, "_flush_entry"}, bus.state_o, S_FLUSH);
        while (bus.state_o != S_RUN && n < 2000) begin
            if (bus.state_o == S_FLUSH) begin
                if (bus.fifo_rst) hi++;
                else              lo++;
            end
            if (bus.state_o == S_FILL && bus.fifo_wr_en && !bus.fifo_rd_en) fill++;
            if (bus.cfg_ready) rdy_bad++;
            tick();
            n++;
        end
        check({tag, "_rst_hi"},     hi,            RST_CYCLES);
        check({tag, "_rst_lo"},     lo,            SETTLE_CYCLES);
        check({tag, "_fill_len"},   fill,          exp_delay);
        check({tag, "_ready_busy"}, rdy_bad,       0);
        check({tag, "_run"},        bus.state_o,   S_RUN);
        check({tag, "_run_wr"},     bus.fifo_wr_en, 1);
        check({tag, "_run_rd"},     bus.fifo_rd_en, 1);
        check({tag, "_running"},    bus.running,   1);
        check({tag, "_flags"},      {bus.ovf_err, bus.udf_err}, 0);
    endtask

    task automatic measure_delay(input int exp_delay, input string tag);
        int n = 0;
        din = 1'b1;
        tick();
        din = 1'b0;
        while (!dout && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_pulse_lag"}, n, exp_delay);
    endtask

    task automatic send_cfg(input int dly);
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = DELAY_W'(dly);
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               en;
        logic               valid;
        logic [DELAY_W-1:0] dly;
        logic [2:0]         st;
        logic               rdy;
        logic               err;
        logic [DELAY_W-1:0] cur;
        logic               frst;
        logic               wr;
        logic               rd;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        //          en    valid dly      st       rdy   err   cur     frst  wr    rd
        vecs[0] = '{1'b0, 1'b1, 10'd0,    S_IDLE,  1'b1, 1'b1, 10'd50,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 10'd1023, S_IDLE,  1'b1, 1'b1, 10'd50,  1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 10'd5,    S_IDLE,  1'b1, 1'b0, 10'd50,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 10'd1022, S_IDLE,  1'b1, 1'b0, 10'd1022,1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 10'd1,    S_IDLE,  1'b1, 1'b0, 10'd1,   1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'd50,   S_IDLE,  1'b1, 1'b0, 10'd50,  1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 10'd0,    S_FLUSH, 1'b0, 1'b0, 10'd50,  1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 10'd10,   S_FLUSH, 1'b0, 1'b0, 10'd50,  1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 10'd10,   S_IDLE,  1'b1, 1'b0, 10'd50,  1'b0, 1'b0, 1'b0};

        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_delay = '0;

        // Reset.
        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check("post_reset_fifo_rst", bus.fifo_rst, 0);
        check("post_reset_state",    bus.state_o,  S_IDLE);

        // Config handshake vectors, one per cycle.
        for (int i = 0; i < 9; i++) begin
            bus.enable    = vecs[i].en;
            bus.cfg_valid = vecs[i].valid;
            bus.cfg_delay = vecs[i].dly;
            tick();
            check($sformatf("vec%0d_state", i),    bus.state_o,    vecs[i].st);
            check($sformatf("vec%0d_ready", i),    bus.cfg_ready,  vecs[i].rdy);
            check($sformatf("vec%0d_cfg_err", i),  bus.cfg_err,    vecs[i].err);
            check($sformatf("vec%0d_delay", i),    bus.delay_cur,  vecs[i].cur);
            check($sformatf("vec%0d_fifo_rst", i), bus.fifo_rst,   vecs[i].frst);
            check($sformatf("vec%0d_wr", i),       bus.fifo_wr_en, vecs[i].wr);
            check($sformatf("vec%0d_rd", i),       bus.fifo_rd_en, vecs[i].rd);
        end
        bus.cfg_valid = 1'b0;

        // Default boot sequence.
        bus.enable = 1'b1;
        tick();
        run_flush_fill(50, "boot");
        measure_delay(50, "boot");

        // Reprogram to 10 while running.
        send_cfg(10);
        check("cfg10_delay", bus.delay_cur, 10);
        run_flush_fill(10, "cfg10");
        measure_delay(10, "cfg10");

        // Out-of-range configs in RUN.
        send_cfg(0);
        check("bad0_cfg_err", bus.cfg_err,   1);
        check("bad0_delay",   bus.delay_cur, 10);
        check("bad0_state",   bus.state_o,   S_RUN);
        tick();
        check("bad0_err_pulse", bus.cfg_err, 0);
        send_cfg(DEPTH - 1);
        check("bad1023_cfg_err", bus.cfg_err,   1);
        check("bad1023_delay",   bus.delay_cur, 10);
        check("bad1023_state",   bus.state_o,   S_RUN);
        tick();
        check("bad1023_err_pulse", bus.cfg_err, 0);

        // cfg_valid held through FLUSH/FILL: accepted only from RUN.
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 10'd20;
        tick();
        bus.cfg_delay = 10'd30;
        check("held_delay20", bus.delay_cur, 20);
        run_flush_fill(20, "held");
        check("held_not_taken", bus.delay_cur, 20);
        tick();
        bus.cfg_valid = 1'b0;
        check("held_taken_delay", bus.delay_cur, 30);
        run_flush_fill(30, "cfg30");

        // Overflow in RUN.
        force_full = 1'b1;
        tick();
        force_full = 1'b0;
        check("ovf_state",   bus.state_o,    S_ERROR);
        check("ovf_flag",    bus.ovf_err,    1);
        check("ovf_udf",     bus.udf_err,    0);
        check("ovf_wr",      bus.fifo_wr_en, 0);
        check("ovf_rd",      bus.fifo_rd_en, 0);
        check("ovf_ready",   bus.cfg_ready,  1);
        tick();
        check("ovf_sticky",  bus.ovf_err,    1);
        check("ovf_hold",    bus.state_o,    S_ERROR);
        bus.enable = 1'b0;
        tick();
        check("dis_state",   bus.state_o, S_IDLE);
        check("dis_clr_ovf", bus.ovf_err, 0);
        bus.enable = 1'b1;
        tick();
        run_flush_fill(30, "reen");

        // Underflow in RUN, then a config from ERROR.
        force_empty = 1'b1;
        tick();
        force_empty = 1'b0;
        check("udf_state", bus.state_o, S_ERROR);
        check("udf_flag",  bus.udf_err, 1);
        check("udf_ovf",   bus.ovf_err, 0);
        send_cfg(30);
        check("errcfg_state", bus.state_o, S_FLUSH);
        check("errcfg_flags", {bus.ovf_err, bus.udf_err}, 0);
        run_flush_fill(30, "errcfg");

        // Both flags at once.
        force_full  = 1'b1;
        force_empty = 1'b1;
        tick();
        force_full  = 1'b0;
        force_empty = 1'b0;
        check("both_state", bus.state_o, S_ERROR);
        check("both_flags", {bus.ovf_err, bus.udf_err}, 2'b11);

        // Drop enable at FILL count 20 of 50.
        send_cfg(50);
        begin
            int n = 0;
            while (bus.state_o != S_FILL && n < 200) begin
                tick();
                n++;
            end
        end
        check("midfill_in_fill", bus.state_o, S_FILL);
        repeat (20) tick();
        check("midfill_still_fill", bus.state_o,    S_FILL);
        check("midfill_wr",         bus.fifo_wr_en, 1);
        bus.enable = 1'b0;
        tick();
        check("midfill_idle",    bus.state_o,    S_IDLE);
        check("midfill_wr_drop", bus.fifo_wr_en, 0);
        bus.enable = 1'b1;
        tick();
        run_flush_fill(50, "refill");

        // rst in the middle of RUN at delay 10.
        send_cfg(10);
        run_flush_fill(10, "pre_rst");
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        rst = 1'b0;
        bus.enable = 1'b0;
        tick();
        check("midrst_after_state",    bus.state_o,  S_IDLE);
        check("midrst_after_fifo_rst", bus.fifo_rst, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
